fixed_sub_sat: RTL and testbench
================================

FIXED_SUB_SAT -- requirements
Module: fixed_sub_sat

Interface
REQ-001 Parameter data_width, default 16: total word width of operands and result.
REQ-002 Parameter frac_width, default 14: fractional bits (signed Q int_width.frac_width).
REQ-003 Parameter int_width, default 2: integer bits including sign; data_width SHALL equal int_width+frac_width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 A_in  input  data_width  signed minuend.
REQ-007 B_in  input  data_width  signed subtrahend.
REQ-008 in_valid  input  1  A_in/B_in carry a valid operand pair.
REQ-009 in_ready  output  1  block accepts the pair this cycle.
REQ-010 out  output  data_width  signed saturated difference A_in-B_in.
REQ-011 out_valid  output  1  out and per-result flags are valid.
REQ-012 out_ready  input  1  downstream accepts out this cycle.
REQ-013 overflow_flag  output  1  current result saturated positive.
REQ-014 underflow_flag  output  1  current result saturated negative.
REQ-015 clear_stats  input  1  synchronous clear of sticky flags and event counter.
REQ-016 sticky_ovf  output  1  any overflow since last clear/reset.
REQ-017 sticky_unf  output  1  any underflow since last clear/reset.
REQ-018 sat_count  output  8  number of saturated results delivered, saturating at 255.

Function
REQ-019 Input handshake: pair accepted on a rising edge where in_valid=1 and in_ready=1; output transfer on a rising edge where out_valid=1 and out_ready=1.
REQ-020 Two-stage pipeline: stage 1 registers the full-precision difference (data_width+1 bits, sign-extended operands); stage 2 registers saturated result and flags.
REQ-021 Stage 2 loads when stage 1 is valid and (out_valid=0 or out_ready=1); stage 1 loads when in_valid=1 and (stage 1 empty or stage 2 loads).
REQ-022 in_ready = (stage 1 empty) or (stage 2 loads this cycle); combinational from out_ready, no in_valid dependency.
REQ-023 Latency: out_valid asserts exactly 2 cycles after acceptance with out_ready held 1; sustained throughput one result per cycle.
REQ-024 Results delivered strictly in acceptance order; none dropped or duplicated under any in_valid/out_ready pattern.
REQ-025 While out_valid=1 and out_ready=0, out and both flags SHALL hold stable.
REQ-026 Difference above 2^(data_width-1)-1 LSB: out = 0111..1, overflow_flag=1, underflow_flag=0.
REQ-027 Difference below -2^(data_width-1) LSB: out = 1000..0, underflow_flag=1, overflow_flag=0.
REQ-028 Otherwise out = exact difference, both flags 0; flags never both 1.
REQ-029 Binary point is identical for operands and result; no rounding, no shifting.
REQ-030 sticky_ovf/sticky_unf set on the output transfer of a result with the matching flag; sat_count increments by 1 on that transfer, holding at 255.
REQ-031 clear_stats=1 clears sticky flags and sat_count; if a saturated transfer coincides, clear wins (values 0 next cycle).

Reset
REQ-032 While reset=0: both stages empty, in_ready=0, out_valid=0, out=0, overflow_flag=0, underflow_flag=0, sticky_ovf=0, sticky_unf=0, sat_count=0.
REQ-033 Reset asserted mid-operation discards all in-flight pairs immediately (asynchronous); none emerge after release.
REQ-034 First acceptance possible on the first rising edge after reset returns to 1 (in_ready=1 then).

Verification
REQ-035 A=0x000C, B=0x0003, out_ready=1 -> out=0x0009, flags 0, out_valid 2 cycles after acceptance.
REQ-036 A=0x7FFF, B=0xFFFF -> out=0x7FFF, overflow_flag=1, sticky_ovf=1, sat_count=1 after transfer.
REQ-037 A=0x8000, B=0x0001 -> out=0x8000, underflow_flag=1; A=0x8000, B=0x8000 -> out=0x0000, flags 0.
REQ-038 Four back-to-back pairs, out_ready=0 for 3 cycles -> in_ready drops after 2 held pairs; all 4 results emerge in order once out_ready=1, out stable while stalled.
REQ-039 260 consecutive overflowing pairs -> sat_count stops at 255; clear_stats pulse coincident with a saturated transfer -> sat_count=0, sticky flags 0.
REQ-040 reset=0 asserted with 2 pairs in flight -> out_valid=0 immediately, no stale result after release.

Source files
------------

// File: rtl/fixed_sub_sat.sv
// Saturating signed fixed-point subtractor (A_in - B_in) with a two-stage
// valid/ready pipeline and sticky saturation statistics.
module fixed_sub_sat #(
  parameter int data_width = 16,
  parameter int frac_width = 14,
  parameter int int_width  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] A_in,
  input  logic [data_width-1:0] B_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [data_width-1:0] out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow_flag,
  output logic                  underflow_flag,
  input  logic                  clear_stats,
  output logic                  sticky_ovf,
  output logic                  sticky_unf,
  output logic [7:0]            sat_count
);

  // Handshakes: a word moves on a rising edge where valid and ready are both 1;
  // a producer holds valid and its data until that edge; ready never looks at valid.

  if (data_width != int_width + frac_width) begin : g_bad_width
    $error("fixed_sub_sat: data_width must equal int_width + frac_width");
  end

  localparam logic [data_width-1:0] max_val = {1'b0, {(data_width-1){1'b1}}};
  localparam logic [data_width-1:0] min_val = {1'b1, {(data_width-1){1'b0}}};

  logic                  s1_valid;
  logic [data_width:0]   s1_diff;
  logic                  s1_load;
  logic                  s2_load;
  logic                  sat_ovf;
  logic                  sat_unf;
  logic [data_width-1:0] sat_val;
  logic                  out_xfer;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = reset && (!s1_valid || s2_load);
  assign s1_load  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // The extra bit holds the exact difference; top two bits disagreeing means
  // the value does not fit in data_width bits.
  always_comb begin
    sat_ovf = !s1_diff[data_width] &&  s1_diff[data_width-1];
    sat_unf =  s1_diff[data_width] && !s1_diff[data_width-1];
    sat_val = s1_diff[data_width-1:0];
    if (sat_ovf) begin
      sat_val = max_val;
    end else if (sat_unf) begin
      sat_val = min_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
    end else begin
      s1_valid <= s1_load || (s1_valid && !s2_load);
      if (s1_load) begin
        s1_diff <= {A_in[data_width-1], A_in} - {B_in[data_width-1], B_in};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid      <= 1'b0;
      out            <= '0;
      overflow_flag  <= 1'b0;
      underflow_flag <= 1'b0;
    end else if (s2_load) begin
      out_valid      <= 1'b1;
      out            <= sat_val;
      overflow_flag  <= sat_ovf;
      underflow_flag <= sat_unf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Statistics follow delivered results, not computed ones; clear has priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky_ovf <= 1'b0;
      sticky_unf <= 1'b0;
      sat_count  <= 8'd0;
    end else if (clear_stats) begin
      sticky_ovf <= 1'b0;
      sticky_unf <= 1'b0;
      sat_count  <= 8'd0;
    end else if (out_xfer) begin
      if (overflow_flag) begin
        sticky_ovf <= 1'b1;
      end
      if (underflow_flag) begin
        sticky_unf <= 1'b1;
      end
      if ((overflow_flag || underflow_flag) && sat_count != 8'hFF) begin
        sat_count <= sat_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fixed_sub_sat.sv
// Bench for fixed_sub_sat: directed cases plus random traffic against an
// integer-arithmetic reference and a scoreboard queue.
module tb_fixed_sub_sat;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] A_in, B_in;
  logic         in_valid, in_ready;
  logic [W-1:0] out;
  logic         out_valid, out_ready;
  logic         overflow_flag, underflow_flag;
  logic         clear_stats;
  logic         sticky_ovf, sticky_unf;
  logic [7:0]   sat_count;

  int n_checks = 0;
  int n_pass   = 0;

  // expected entries are {overflow, underflow, out}
  logic [W+1:0] exp_q[$];
  logic         m_ovf, m_unf;
  int           m_cnt;
  logic         prev_stall;
  logic [W+1:0] prev_word;

  fixed_sub_sat #(.data_width(16), .frac_width(14), .int_width(2)) dut (
    .clk(clk), .reset(reset), .A_in(A_in), .B_in(B_in),
    .in_valid(in_valid), .in_ready(in_ready), .out(out),
    .out_valid(out_valid), .out_ready(out_ready),
    .overflow_flag(overflow_flag), .underflow_flag(underflow_flag),
    .clear_stats(clear_stats), .sticky_ovf(sticky_ovf),
    .sticky_unf(sticky_unf), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    int d;
    logic [W+1:0] r;
    d = int'($signed(a)) - int'($signed(b));
    if (d > 32767)       r = {2'b10, 16'h7FFF};
    else if (d < -32768) r = {2'b01, 16'h8000};
    else                 r = {2'b00, d[15:0]};
    return r;
  endfunction

  // Scoreboard / statistics model, evaluated mid-cycle
  always @(negedge clk) begin
    logic [W+1:0] e;
    logic         have_e;
    if (!reset) begin
      exp_q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_cnt = 0;
      prev_stall = 1'b0;
    end else begin
      have_e = 1'b0;
      e = '0;
      check("in_ready", {31'd0, in_ready}, {31'd0, (exp_q.size() < 2) || out_ready});
      check("stats", {22'd0, sticky_ovf, sticky_unf, sat_count}, {22'd0, m_ovf, m_unf, m_cnt[7:0]});
      if (prev_stall && out_valid)
        check("hold", {14'd0, overflow_flag, underflow_flag, out}, {14'd0, prev_word});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {14'd0, overflow_flag, underflow_flag, out}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          have_e = 1'b1;
          check("result", {14'd0, overflow_flag, underflow_flag, out}, {14'd0, e});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {overflow_flag, underflow_flag, out};
      if (clear_stats) begin
        m_ovf = 1'b0; m_unf = 1'b0; m_cnt = 0;
      end else if (have_e && (e[W+1] || e[W])) begin
        if (e[W+1]) m_ovf = 1'b1;
        if (e[W])   m_unf = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
      if (in_valid && in_ready) exp_q.push_back(ref_sub(A_in, B_in));
    end
  end

  // Call at posedge+#1; returns at posedge+#1 after the pair is accepted.
  task automatic drive_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    A_in = a; B_in = b; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !out_valid) return;
    end
    check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic fire;
    logic got_valid;
    reset = 1'b0; in_valid = 1'b0; A_in = '0; B_in = '0;
    out_ready = 1'b1; clear_stats = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out", {16'd0, out}, 32'd0);
    check("rst_flags", {30'd0, overflow_flag, underflow_flag}, 32'd0);
    check("rst_sticky", {30'd0, sticky_ovf, sticky_unf}, 32'd0);
    check("rst_count", {24'd0, sat_count}, 32'd0);

    // Release, first acceptance and latency
    @(posedge clk); #1;
    reset = 1'b1;
    A_in = 16'h000C; B_in = 16'h0003; in_valid = 1'b1;
    #1 check("first_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_2", {31'd0, out_valid}, 32'd1);
    check("lat_out", {14'd0, overflow_flag, underflow_flag, out}, 32'h0000_0009);
    drain();

    // Saturation corners
    drive_pair(16'h7FFF, 16'hFFFF);
    drain();
    check("ovf_sticky", {31'd0, sticky_ovf}, 32'd1);
    check("ovf_count", {24'd0, sat_count}, 32'd1);
    drive_pair(16'h8000, 16'h0001);
    drive_pair(16'h8000, 16'h8000);
    drain();
    check("unf_sticky", {30'd0, sticky_ovf, sticky_unf}, 32'd3);

    // Four pairs into a stalled output
    out_ready = 1'b0;
    fork
      begin
        drive_pair(16'h0100, 16'h0001);
        drive_pair(16'h7000, 16'h9000);
        drive_pair(16'h9000, 16'h7000);
        drive_pair(16'h1234, 16'h1234);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Counter saturation, then clear coincident with a saturated transfer
    for (int i = 0; i < 260; i++) drive_pair(16'h7FFF, 16'h8000);
    drain();
    check("count_cap", {24'd0, sat_count}, 32'd255);
    out_ready = 1'b0;
    drive_pair(16'h8000, 16'h7FFF);
    got_valid = 1'b0;
    for (int i = 0; i < 20 && !got_valid; i++) begin
      @(posedge clk); #1;
      got_valid = out_valid;
    end
    check("clr_wait", {31'd0, got_valid}, 32'd1);
    out_ready = 1'b1; clear_stats = 1'b1;
    @(posedge clk); #1;
    clear_stats = 1'b0;
    check("clr_count", {24'd0, sat_count}, 32'd0);
    check("clr_sticky", {30'd0, sticky_ovf, sticky_unf}, 32'd0);
    drain();

    // Asynchronous reset with two pairs in flight
    out_ready = 1'b0;
    drive_pair(16'h0005, 16'h0001);
    drive_pair(16'h0007, 16'h0002);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd0);
    check("arst_count", {24'd0, sat_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale", {31'd0, out_valid}, 32'd0);
    end

    // Random traffic
    @(posedge clk); #1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      if (!in_valid || fire) begin
        in_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1) begin
          A_in = W'($urandom);
          B_in = W'($urandom);
        end else begin
          A_in = $urandom_range(0, 1) ? 16'h7F00 + W'($urandom_range(0, 255)) : 16'h8000 + W'($urandom_range(0, 255));
          B_in = $urandom_range(0, 1) ? 16'h7F00 + W'($urandom_range(0, 255)) : 16'h8000 + W'($urandom_range(0, 255));
        end
      end
      out_ready   = ($urandom_range(0, 2) != 0);
      clear_stats = ($urandom_range(0, 31) == 0);
    end
    in_valid = 1'b0; clear_stats = 1'b0; out_ready = 1'b1;
    drain();
    check("final_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
